mux_nx1_scan: RTL and testbench

//   Parametrised N-channel, W-bit registered multiplexer with a valid/ready output.

---
 rtl/mux_scan_pkg.sv | 14 +
 rtl/scan_seq.sv | 69 ++++++
 rtl/mux_nx1_scan.sv | 106 ++++++++++
 tb/tb_mux_nx1_scan.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// rtl/mux_scan_pkg.sv - shared types and encodings for the scanning N:1 multiplexer
// Purpose: FSM state enum and mode-pin encodings used by mux_nx1_scan.
// Ports: none (package).
package mux_scan_pkg;

  typedef enum logic [0:0] {
    MANUAL = 1'b0,
    SCAN   = 1'b1
  } state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/scan_seq.sv
// rtl/scan_seq.sv - scan pointer and dwell counter for time-division readout
// Purpose: steps a channel pointer 0..N-1, holding each channel for DWELL accepted beats.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clear       return pointer and dwell count to zero (takes priority over advance)
//   advance     one scan-sourced beat was accepted this cycle
//   ptr         channel to load on this cycle's edge (look-ahead of the pointer register)
//   wrap        registered 1-cycle pulse after the pointer wrapped from N-1 to 0
module scan_seq #(
  parameter  int N     = 4,
  parameter  int DWELL = 4,
  localparam int SELW  = $clog2(N),
  localparam int CW    = $clog2(DWELL + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            advance,
  output logic [SELW-1:0] ptr,
  output logic            wrap
);

  localparam logic [SELW-1:0] LAST_PTR = SELW'(N - 1);
  localparam logic [CW-1:0]   LAST_CNT = CW'(DWELL - 1);

  logic [SELW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wrap_q, wrap_d;

  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (clear) begin
      ptr_d = '0;
      cnt_d = '0;
    end else if (advance) begin
      if (cnt_q == LAST_CNT) begin
        cnt_d = '0;
        if (ptr_q == LAST_PTR) begin
          ptr_d  = '0;
          wrap_d = 1'b1;
        end else begin
          ptr_d = ptr_q + SELW'(1);
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  // The load that coincides with an accept must already see the advanced
  // pointer, otherwise each channel would be shown one beat too long.
  assign ptr  = ptr_d;
  assign wrap = wrap_q;

endmodule

// File: rtl/mux_nx1_scan.sv
// rtl/mux_nx1_scan.sv - N-channel registered multiplexer with manual and scan modes
// Purpose: selects one of N W-bit channels into a valid/ready output register, either
//          by sel (manual) or by an internal round-robin sequencer (scan).
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   d           flattened channel inputs, channel i = d[i*W +: W]
//   sel         manual-mode channel select (values >= N give zero data)
//   mode        0 = manual, 1 = scan
//   en          allow new output loads
//   y, y_valid  registered output beat and its valid flag
//   y_ready     consumer accept
//   cur_ch      channel index of the beat in y
//   scan_wrap   1-cycle pulse after the last beat of channel N-1 was accepted in scan mode
module mux_nx1_scan
  import mux_scan_pkg::*;
#(
  parameter  int N     = 4,
  parameter  int W     = 8,
  parameter  int DWELL = 4,
  localparam int SELW  = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*W-1:0]  d,
  input  logic [SELW-1:0] sel,
  input  logic            mode,
  input  logic            en,
  output logic [W-1:0]    y,
  output logic            y_valid,
  input  logic            y_ready,
  output logic [SELW-1:0] cur_ch,
  output logic            scan_wrap
);

  state_t state_q, state_d;

  logic            accept;
  logic            load;
  logic            use_scan;
  logic            entering;
  logic            src_scan_q;
  logic [SELW-1:0] ptr;
  logic [SELW-1:0] sel_ch;
  logic [W-1:0]    ch_data;

  assign accept   = y_valid && y_ready;
  assign load     = en && (!y_valid || y_ready);
  // The mode pin picks the source of the next load directly; a stalled beat
  // keeps whatever source it was loaded from.
  assign use_scan = (mode == MODE_SCAN);
  assign entering = (state_q == MANUAL) && use_scan;

  always_comb begin
    state_d = state_q;
    case (state_q)
      MANUAL:  if (mode == MODE_SCAN)   state_d = SCAN;
      SCAN:    if (mode == MODE_MANUAL) state_d = MANUAL;
      default: state_d = MANUAL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= MANUAL;
    else        state_q <= state_d;
  end

  // Dwell only counts beats that were actually sourced by the sequencer.
  scan_seq #(
    .N     (N),
    .DWELL (DWELL)
  ) u_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (entering),
    .advance (accept && src_scan_q),
    .ptr     (ptr),
    .wrap    (scan_wrap)
  );

  assign sel_ch = use_scan ? ptr : sel;

  // Out-of-range selects match no channel and yield zero.
  always_comb begin
    ch_data = '0;
    for (int i = 0; i < N; i++) begin
      if (sel_ch == SELW'(i)) ch_data = d[i*W +: W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y          <= '0;
      y_valid    <= 1'b0;
      cur_ch     <= '0;
      src_scan_q <= 1'b0;
    end else if (load) begin
      y          <= ch_data;
      y_valid    <= 1'b1;
      cur_ch     <= sel_ch;
      src_scan_q <= use_scan;
    end else if (accept) begin
      y_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_nx1_scan.sv
// tb/tb_mux_nx1_scan.sv - directed self-checking bench for mux_nx1_scan
module tb_mux_nx1_scan;

  localparam int N     = 4;
  localparam int W     = 8;
  localparam int DWELL = 2;
  localparam int SELW  = $clog2(N);

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*W-1:0]  d;
  logic [SELW-1:0] sel;
  logic            mode;
  logic            en;
  logic [W-1:0]    y;
  logic            y_valid;
  logic            y_ready;
  logic [SELW-1:0] cur_ch;
  logic            scan_wrap;

  int checks = 0;
  int errors = 0;

  localparam logic [N*W-1:0] D_NOM = {8'hDD, 8'hCC, 8'hBB, 8'hAA};

  int man_y  [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
  int scan_y [9] = '{8'hAA, 8'hAA, 8'hBB, 8'hBB, 8'hCC, 8'hCC, 8'hDD, 8'hDD, 8'hAA};
  int scan_c [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
  int scan_w [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};

  mux_nx1_scan #(.N(N), .W(W), .DWELL(DWELL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .d         (d),
    .sel       (sel),
    .mode      (mode),
    .en        (en),
    .y         (y),
    .y_valid   (y_valid),
    .y_ready   (y_ready),
    .cur_ch    (cur_ch),
    .scan_wrap (scan_wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_beat(input string tag, input int ey, input int ec);
    check({tag, ".y"},       32'(y),       32'(ey));
    check({tag, ".valid"},   32'(y_valid), 32'd1);
    check({tag, ".cur_ch"},  32'(cur_ch),  32'(ec));
  endtask

  initial begin
    rst_n   = 1'b0;
    d       = D_NOM;
    sel     = '0;
    mode    = 1'b0;
    en      = 1'b0;
    y_ready = 1'b1;
    step();
    step();
    check("rst.y",     32'(y),         32'h0);
    check("rst.valid", 32'(y_valid),   32'h0);
    check("rst.cur_ch",32'(cur_ch),    32'h0);
    check("rst.wrap",  32'(scan_wrap), 32'h0);

    // manual select sweep
    rst_n = 1'b1;
    en    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel = SELW'(i);
      step();
      check_beat("manual", man_y[i], i);
    end

    // scan sequence with wrap pulse
    mode = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      check_beat("scan", scan_y[i], scan_c[i]);
      check("scan.wrap", 32'(scan_wrap), 32'(scan_w[i]));
    end
    step();
    check_beat("scan2_a", 8'hAA, 0);
    check("scan2.wrap", 32'(scan_wrap), 32'h0);
    step();
    check_beat("scan2_b", 8'hBB, 1);

    // backpressure on the first BB while d churns
    y_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d = {8'h11, 8'h22, 8'h33, 8'(8'h40 + i)};
      step();
      check_beat("stall", 8'hBB, 1);
    end
    d       = D_NOM;
    y_ready = 1'b1;
    step();
    check_beat("resume_bb", 8'hBB, 1);
    step();
    check_beat("resume_cc", 8'hCC, 2);

    // asynchronous reset while scanning ch2
    rst_n = 1'b0;
    #1;
    check("arst.y",     32'(y),       32'h0);
    check("arst.valid", 32'(y_valid), 32'h0);
    check("arst.cur_ch",32'(cur_ch),  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_beat("rest_a0", 8'hAA, 0);
    step();
    check_beat("rest_a1", 8'hAA, 0);
    step();
    check_beat("rest_b0", 8'hBB, 1);
    step();
    step();
    check_beat("rest_c0", 8'hCC, 2);

    // mode switch to manual and back
    mode = 1'b0;
    sel  = 2'd3;
    step();
    check_beat("sw_dd", 8'hDD, 3);
    step();
    check_beat("sw_dd2", 8'hDD, 3);
    mode = 1'b1;
    step();
    check_beat("sw_aa", 8'hAA, 0);
    step();
    check_beat("sw_aa2", 8'hAA, 0);
    step();
    check_beat("sw_bb", 8'hBB, 1);

    // enable drop: beat consumed, output holds, then reload
    en = 1'b0;
    step();
    check("en0.valid", 32'(y_valid), 32'h0);
    check("en0.y",     32'(y),       32'hBB);
    step();
    check("en0b.valid", 32'(y_valid), 32'h0);
    en = 1'b1;
    step();
    check_beat("en1_bb", 8'hBB, 1);
    step();
    check_beat("en1_cc", 8'hCC, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
